// File: rtl/lcd_spi_if.sv
// CPU-side bus for the LCD SPI slot: write strobe(s), write data and status readback.
// Latency: none (wires only).
// Backpressure: none on the bus; software polls out[15] (busy) before writing.
//
// Macro: LCD_WORD16_EN adds the 16-bit pixel write strobe load16.
// Signals:
//   load    write strobe for the slot
//   load16  16-bit pixel write strobe (LCD_WORD16_EN only)
//   in      CPU store data
//   out     status word returned to the CPU read mux
interface lcd_spi_if;
    logic        load;
`ifdef LCD_WORD16_EN
    logic        load16;
`endif
    logic [15:0] in;
    logic [15:0] out;

    modport master (
        output load,
`ifdef LCD_WORD16_EN
        output load16,
`endif
        output in,
        input  out
    );

    modport slave (
        input  load,
`ifdef LCD_WORD16_EN
        input  load16,
`endif
        input  in,
        output out
    );
endinterface

// File: rtl/lcd_spi.sv
// Write-only SPI master (mode 0, MSB first) for the ILI9341 pins, with select release and busy status.
// Latency: a send is 16*DIV busy cycles per byte (32*DIV per 16-bit word); a release shows CSX=1 one cycle after the write.
// Backpressure: none; any write seen while busy is dropped, and software polls out[15].
//
// Macro: LCD_WORD16_EN enables bus.load16 (16-bit RGB565 send with DCX forced to 1).
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   bus (slave)     load/in write strobe and data, out status {busy,5'b0,DCX,CSX,8'b0}
//   CSX,DCX,SCK,SDO LCD pins
// Parameter DIV (1..255): SCK half-period in clk cycles.
module lcd_spi #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    lcd_spi_if.slave   bus,
    output logic       CSX,
    output logic       DCX,
    output logic       SCK,
    output logic       SDO
);

`ifdef LCD_WORD16_EN
    localparam int SW = 16;
`else
    localparam int SW = 8;
`endif

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic          csx_q, csx_d;
    logic          dcx_q, dcx_d;
    logic          sck_q, sck_d;
    logic          sdo_q, sdo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            csx_q     <= 1'b1;
            dcx_q     <= 1'b0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            csx_q     <= csx_d;
            dcx_q     <= dcx_d;
            sck_q     <= sck_d;
            sdo_q     <= sdo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        csx_d     = csx_q;
        dcx_d     = dcx_q;
        sck_d     = sck_q;
        sdo_d     = sdo_q;

        unique case (state_q)
            IDLE: begin
`ifdef LCD_WORD16_EN
                // load16 has priority over a simultaneous byte write.
                if (bus.load16) begin
                    shreg_d   = bus.in;
                    sdo_d     = bus.in[15];
                    dcx_d     = 1'b1;
                    csx_d     = 1'b0;
                    bit_cnt_d = 8'd16;
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    state_d   = SHIFT;
                end else
`endif
                if (bus.load) begin
                    if (!bus.in[8]) begin
                        // Byte is MSB-aligned so the same shift path serves 8- and 16-bit sends.
                        shreg_d           = '0;
                        shreg_d[SW-1 -: 8] = bus.in[7:0];
                        sdo_d             = bus.in[7];
                        dcx_d             = bus.in[9];
                        csx_d             = 1'b0;
                        bit_cnt_d         = 8'd8;
                        div_cnt_d         = '0;
                        sck_d             = 1'b0;
                        state_d           = SHIFT;
                    end else begin
                        // Release: only the select moves; DCX and SDO keep their levels.
                        csx_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // End of the high phase closes the current bit.
                        sck_d = 1'b0;
                        if (bit_cnt_q == 8'd1) begin
                            // SDO keeps the last bit; CSX stays low for follow-on bytes.
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end else begin
                            shreg_d   = shreg_q << 1;
                            sdo_d     = shreg_q[SW-2];
                            bit_cnt_d = bit_cnt_q - 8'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

`ifndef LCD_WORD16_EN
    logic unused_in_hi;
    assign unused_in_hi = ^bus.in[15:10];
`endif

    assign bus.out = {(state_q == SHIFT), 5'b0, dcx_q, csx_q, 8'b0};
    assign CSX     = csx_q;
    assign DCX     = dcx_q;
    assign SCK     = sck_q;
    assign SDO     = sdo_q;

endmodule

// File: tb/tb_lcd_spi.sv
// Self-checking bench for lcd_spi: two instances (DIV=1 and DIV=3) driven from tables and hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_spi;

    logic        clk;
    logic        rst [2];
    logic        ld  [2];
    logic        l16 [2];
    logic [15:0] din [2];
    logic        csx_w [2];
    logic        dcx_w [2];
    logic        sck_w [2];
    logic        sdo_w [2];
    logic [15:0] out_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    lcd_spi_if if1 ();
    lcd_spi_if if3 ();

    assign if1.load = ld[0];
    assign if1.in   = din[0];
    assign if3.load = ld[1];
    assign if3.in   = din[1];
`ifdef LCD_WORD16_EN
    assign if1.load16 = l16[0];
    assign if3.load16 = l16[1];
`endif
    assign out_w[0] = if1.out;
    assign out_w[1] = if3.out;

    lcd_spi #(.DIV(1)) dut1 (
        .clk(clk), .reset(rst[0]), .bus(if1),
        .CSX(csx_w[0]), .DCX(dcx_w[0]), .SCK(sck_w[0]), .SDO(sdo_w[0])
    );

    lcd_spi #(.DIV(3)) dut3 (
        .clk(clk), .reset(rst[1]), .bus(if3),
        .CSX(csx_w[1]), .DCX(dcx_w[1]), .SCK(sck_w[1]), .SDO(sdo_w[1])
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one send (called right after a negedge) and follows it to completion,
    // checking the bit stream, SCK phase lengths, busy width and final pin levels.
    // With inj set, a send and a release are written mid-transfer and must be dropped.
    task automatic xfer(input int sel, input logic [15:0] d, input bit w16, input bit inj,
                        input int div, input logic [15:0] exp_bits, input int nbits,
                        input logic exp_dcx);
        int          busy_cnt = 0;
        int          rises = 0;
        int          bad_runs = 0;
        int          csx_hi = 0;
        int          run = 0;
        int          guard = 0;
        logic        prev = 1'b0;
        logic [15:0] bits = '0;
        if (w16) l16[sel] = 1'b1; else ld[sel] = 1'b1;
        din[sel] = d;
        @(negedge clk);
        ld[sel]  = 1'b0;
        l16[sel] = 1'b0;
        chk("start_csx", 32'(csx_w[sel]), 32'd0);
        chk("start_dcx", 32'(dcx_w[sel]), 32'(exp_dcx));
        chk("start_sdo", 32'(sdo_w[sel]), 32'(exp_bits[nbits-1]));
        chk("start_out", 32'(out_w[sel]), 32'h8000 | (32'(exp_dcx) << 9));
        while (out_w[sel][15] === 1'b1 && guard < 4000) begin
            guard++;
            if (sck_w[sel] === prev) begin
                run++;
            end else begin
                if (run != div) bad_runs++;
                if (sck_w[sel] === 1'b1) begin
                    bits = {bits[14:0], sdo_w[sel]};
                    rises++;
                end
                run  = 1;
                prev = sck_w[sel];
            end
            if (csx_w[sel] !== 1'b0) csx_hi++;
            busy_cnt++;
            ld[sel] = 1'b0;
            if (inj && busy_cnt == 3) begin
                ld[sel] = 1'b1; din[sel] = 16'h0255;
            end else if (inj && busy_cnt == 6) begin
                ld[sel] = 1'b1; din[sel] = 16'h0100;
            end
            @(negedge clk);
        end
        ld[sel] = 1'b0;
        chk("busy_cycles", 32'(busy_cnt), 32'(nbits * 2 * div));
        chk("sck_rises", 32'(rises), 32'(nbits));
        chk("bits", 32'(bits), 32'(exp_bits));
        chk("sck_phase_len", 32'(bad_runs), 32'd0);
        chk("last_high_len", 32'(run), 32'(div));
        chk("csx_low_during", 32'(csx_hi), 32'd0);
        chk("end_out", 32'(out_w[sel]), 32'(exp_dcx) << 9);
        chk("end_sck", 32'(sck_w[sel]), 32'd0);
        chk("end_sdo_hold", 32'(sdo_w[sel]), 32'(exp_bits[0]));
    endtask

    typedef struct {
        logic [15:0] din;
        logic [7:0]  exp_byte;
        logic        exp_dcx;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int rises;
        int guard;
        logic prev;

        vecs[0] = '{din: 16'h002A, exp_byte: 8'h2A, exp_dcx: 1'b0};
        vecs[1] = '{din: 16'h02FF, exp_byte: 8'hFF, exp_dcx: 1'b1};
        vecs[2] = '{din: 16'h0281, exp_byte: 8'h81, exp_dcx: 1'b1};
        vecs[3] = '{din: 16'h0000, exp_byte: 8'h00, exp_dcx: 1'b0};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ld[i] = 1'b0; l16[i] = 1'b0; din[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("rst_csx", 32'(csx_w[i]), 32'd1);
            chk("rst_dcx", 32'(dcx_w[i]), 32'd0);
            chk("rst_sck", 32'(sck_w[i]), 32'd0);
            chk("rst_sdo", 32'(sdo_w[i]), 32'd0);
            chk("rst_out", 32'(out_w[i]), 32'h0100);
        end

        // Back-to-back byte sends on the DIV=1 instance.
        for (int i = 0; i < 4; i++)
            xfer(0, vecs[i].din, 1'b0, 1'b0, 1, {8'h00, vecs[i].exp_byte}, 8, vecs[i].exp_dcx);

        // Writes during a transfer are dropped, then a release from idle.
        xfer(0, 16'h0011, 1'b0, 1'b1, 1, 16'h0011, 8, 1'b0);
        ld[0] = 1'b1; din[0] = 16'h0100;
        @(negedge clk);
        ld[0] = 1'b0;
        chk("rel_csx", 32'(csx_w[0]), 32'd1);
        chk("rel_out", 32'(out_w[0]), 32'h0100);
        chk("rel_dcx", 32'(dcx_w[0]), 32'd0);
        chk("rel_sdo", 32'(sdo_w[0]), 32'd1);
        repeat (2) @(negedge clk);
        chk("rel_idle_out", 32'(out_w[0]), 32'h0100);

        // DIV=3 data byte; select stays low afterwards.
        xfer(1, 16'h02C3, 1'b0, 1'b0, 3, 16'h00C3, 8, 1'b1);
        @(negedge clk);
        chk("div3_csx_after", 32'(csx_w[1]), 32'd0);

        // Reset on the 5th SCK rise of a data byte.
        ld[0] = 1'b1; din[0] = 16'h02A5;
        @(negedge clk);
        ld[0] = 1'b0;
        rises = 0; guard = 0; prev = 1'b0;
        while (rises < 5 && guard < 200) begin
            if (sck_w[0] === 1'b1 && prev === 1'b0) rises++;
            prev = sck_w[0];
            guard++;
            if (rises < 5) @(negedge clk);
        end
        chk("rst_mid_reached", 32'(rises), 32'd5);
        #5 rst[0] = 1'b1;
        #1;
        chk("rst_mid_csx", 32'(csx_w[0]), 32'd1);
        chk("rst_mid_dcx", 32'(dcx_w[0]), 32'd0);
        chk("rst_mid_sck", 32'(sck_w[0]), 32'd0);
        chk("rst_mid_sdo", 32'(sdo_w[0]), 32'd0);
        chk("rst_mid_out", 32'(out_w[0]), 32'h0100);
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        xfer(0, 16'h003C, 1'b0, 1'b0, 1, 16'h003C, 8, 1'b0);

`ifdef LCD_WORD16_EN
        // 16-bit pixel send; load16 wins over a simultaneous byte write.
        ld[0] = 1'b1;
        xfer(0, 16'hF800, 1'b1, 1'b0, 1, 16'hF800, 16, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
